// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: stores programmable alarm times, matches them
// against the running clock and sequences ring / snooze / re-ring / timeout.
module alarm_scheduler #(
  parameter int SLOTS          = 4,
  parameter int SNOOZE_MIN     = 9,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3,
  parameter int SLOT_W         = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic [5:0]        cur_hours,
  input  logic [5:0]        cur_minutes,
  input  logic [5:0]        cur_seconds,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic              cfg_en,
  input  logic [5:0]        cfg_hours,
  input  logic [5:0]        cfg_minutes,
  input  logic              snooze,
  input  logic              dismiss,
  output logic              ring,
  output logic              snoozed,
  output logic [SLOT_W-1:0] active_slot,
  output logic [2:0]        snoozes_left,
  output logic              missed
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [15:0] SNZ_LOAD  = 16'(SNOOZE_MIN * 60);
  localparam logic [7:0]  RING_LAST = 8'(RING_TIMEOUT_S - 1);
  localparam logic [2:0]  SNZ_MAX   = 3'(MAX_SNOOZE);

  logic [SLOTS-1:0]      en_reg;
  logic [SLOTS-1:0][5:0] hours_reg;
  logic [SLOTS-1:0][5:0] minutes_reg;
  logic [SLOTS-1:0]      match;

  state_t            state_reg, state_next;
  logic [7:0]        ring_cnt_reg;
  logic [15:0]       snz_cnt_reg;
  logic [SLOT_W-1:0] active_slot_reg;
  logic [2:0]        snoozes_left_reg;
  logic              ring_reg, snoozed_reg, missed_reg;
  logic              ring_next, snoozed_next, missed_next;

  logic              any_match;
  logic [SLOT_W-1:0] win_idx;
  logic              cancel, snooze_ok, timeout, fire_missed;

  // Slot storage; indices outside 0..SLOTS-1 simply hit no slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_reg      <= '0;
      hours_reg   <= '0;
      minutes_reg <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (cfg_slot == SLOT_W'(i)) begin
          en_reg[i]      <= cfg_en;
          hours_reg[i]   <= cfg_hours;
          minutes_reg[i] <= cfg_minutes;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_match
      assign match[gi] = tick && (cur_seconds == 6'd0) && en_reg[gi] &&
                         (hours_reg[gi] == cur_hours) &&
                         (minutes_reg[gi] == cur_minutes);
    end
  endgenerate

  // Lowest matching index wins.
  always_comb begin
    win_idx   = '0;
    any_match = |match;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (match[i]) win_idx = SLOT_W'(i);
    end
  end

  assign cancel    = cfg_we && !cfg_en && (cfg_slot == active_slot_reg);
  assign snooze_ok = snooze && (snoozes_left_reg != 3'd0);
  assign timeout   = tick && (ring_cnt_reg == RING_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    fire_missed = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_match) state_next = RING;
      end
      RING: begin
        if (dismiss || cancel) begin
          state_next = IDLE;
        end else if (snooze_ok) begin
          state_next = SNOOZE;
        end else if (timeout) begin
          state_next  = IDLE;
          fire_missed = 1'b1;
        end
      end
      SNOOZE: begin
        if (dismiss || cancel)                     state_next = IDLE;
        else if (tick && (snz_cnt_reg == 16'd1))   state_next = RING;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ring_next    = (state_next == RING);
    snoozed_next = (state_next == SNOOZE);
    missed_next  = fire_missed;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ring_reg         <= 1'b0;
      snoozed_reg      <= 1'b0;
      missed_reg       <= 1'b0;
      ring_cnt_reg     <= '0;
      snz_cnt_reg      <= '0;
      active_slot_reg  <= '0;
      snoozes_left_reg <= '0;
    end else begin
      ring_reg    <= ring_next;
      snoozed_reg <= snoozed_next;
      missed_reg  <= missed_next;
      case (state_reg)
        IDLE: begin
          if (any_match) begin
            active_slot_reg  <= win_idx;
            snoozes_left_reg <= SNZ_MAX;
            ring_cnt_reg     <= '0;
          end
        end
        RING: begin
          if (state_next == SNOOZE) begin
            snz_cnt_reg      <= SNZ_LOAD;
            snoozes_left_reg <= snoozes_left_reg - 3'd1;
          end else if (state_next == RING && tick) begin
            ring_cnt_reg <= ring_cnt_reg + 8'd1;
          end
        end
        SNOOZE: begin
          if (state_next == RING) ring_cnt_reg <= '0;
          else if (tick)          snz_cnt_reg  <= snz_cnt_reg - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign ring         = ring_reg;
  assign snoozed      = snoozed_reg;
  assign missed       = missed_reg;
  assign active_slot  = active_slot_reg;
  assign snoozes_left = snoozes_left_reg;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: directed scenarios plus random traffic
// against an event-level reference model of the alarm rules.
module tb_alarm_scheduler;
  localparam int SLOTS          = 4;
  localparam int SNOOZE_MIN     = 1;
  localparam int RING_TIMEOUT_S = 4;
  localparam int MAX_SNOOZE     = 3;
  localparam int SLOT_W         = 2;
  localparam int SNZ_TICKS      = SNOOZE_MIN * 60;
  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              tick = 1'b0;
  logic [5:0]        cur_hours = '0, cur_minutes = '0, cur_seconds = '0;
  logic              cfg_we = 1'b0;
  logic [SLOT_W-1:0] cfg_slot = '0;
  logic              cfg_en = 1'b0;
  logic [5:0]        cfg_hours = '0, cfg_minutes = '0;
  logic              snooze = 1'b0, dismiss = 1'b0;
  logic              ring, snoozed, missed;
  logic [SLOT_W-1:0] active_slot;
  logic [2:0]        snoozes_left;

  always #5 clk = ~clk;

  alarm_scheduler #(
    .SLOTS(SLOTS), .SNOOZE_MIN(SNOOZE_MIN), .RING_TIMEOUT_S(RING_TIMEOUT_S),
    .MAX_SNOOZE(MAX_SNOOZE), .SLOT_W(SLOT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_en(cfg_en),
    .cfg_hours(cfg_hours), .cfg_minutes(cfg_minutes),
    .snooze(snooze), .dismiss(dismiss),
    .ring(ring), .snoozed(snoozed), .active_slot(active_slot),
    .snoozes_left(snoozes_left), .missed(missed)
  );

  typedef struct {
    logic ring;
    logic snoozed;
    int   slot;
    int   left;
    logic missed;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: event mode, ticks spent ringing, ticks left in snooze.
  int m_mode, m_slot, m_left, m_rang, m_wait;
  bit m_missed;
  bit m_en[SLOTS];
  int m_h[SLOTS], m_m[SLOTS];
  int th = 0, tm = 0, ts = 0;
  bit rst_next = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE; m_slot = 0; m_left = 0; m_rang = 0; m_wait = 0; m_missed = 0;
    for (int i = 0; i < SLOTS; i++) begin
      m_en[i] = 0; m_h[i] = 0; m_m[i] = 0;
    end
  endfunction

  function automatic void model_step();
    int hit;
    bit cancel;
    hit = -1;
    m_missed = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (tick && cur_seconds == 0)
      for (int i = SLOTS - 1; i >= 0; i--)
        if (m_en[i] && m_h[i] == int'(cur_hours) && m_m[i] == int'(cur_minutes)) hit = i;
    cancel = cfg_we && !cfg_en && int'(cfg_slot) == m_slot;
    case (m_mode)
      M_IDLE: if (hit >= 0) begin
        m_mode = M_RING; m_slot = hit; m_left = MAX_SNOOZE; m_rang = 0;
      end
      M_RING: begin
        if (dismiss || cancel) m_mode = M_IDLE;
        else if (snooze && m_left > 0) begin
          m_mode = M_SNZ; m_left--; m_wait = SNZ_TICKS;
        end else if (tick) begin
          m_rang++;
          if (m_rang == RING_TIMEOUT_S) begin
            m_mode = M_IDLE; m_missed = 1;
          end
        end
      end
      default: begin
        if (dismiss || cancel) m_mode = M_IDLE;
        else if (tick) begin
          m_wait--;
          if (m_wait == 0) begin
            m_mode = M_RING; m_rang = 0;
          end
        end
      end
    endcase
    if (cfg_we && int'(cfg_slot) < SLOTS) begin
      m_en[cfg_slot] = cfg_en;
      m_h[cfg_slot]  = int'(cfg_hours);
      m_m[cfg_slot]  = int'(cfg_minutes);
    end
  endfunction

  task automatic push_exp();
    exp_t e;
    e.ring    = (m_mode == M_RING);
    e.snoozed = (m_mode == M_SNZ);
    e.slot    = m_slot;
    e.left    = m_left;
    e.missed  = m_missed;
    exp_q.push_back(e);
  endtask

  function automatic void advance();
    ts++;
    if (ts == 60) begin
      ts = 0; tm++;
      if (tm == 60) begin
        tm = 0; th++;
        if (th == 24) th = 0;
      end
    end
  endfunction

  task automatic drive(input bit t, input bit snz, input bit dsm, input bit we = 0,
                       input int slot = 0, input bit en = 0, input int h = 0, input int m = 0);
    @(negedge clk);
    reset_n = rst_next;
    if (t) advance();
    tick = t; snooze = snz; dismiss = dsm;
    cfg_we = we; cfg_slot = SLOT_W'(slot); cfg_en = en;
    cfg_hours = 6'(h); cfg_minutes = 6'(m);
    cur_hours = 6'(th); cur_minutes = 6'(tm); cur_seconds = 6'(ts);
    model_step();
    push_exp();
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  task automatic cfg(input int slot, input bit en, input int h, input int m);
    drive(0, 0, 0, 1, slot, en, h, m);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    th = h; tm = m; ts = s;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    rst_next = 1'b0;
    tick = 0; snooze = 0; dismiss = 0; cfg_we = 0;
    #1;
    check("async_rst_ring", int'(ring), 0);
    check("async_rst_snoozed", int'(snoozed), 0);
    check("async_rst_slot", int'(active_slot), 0);
    check("async_rst_left", int'(snoozes_left), 0);
    check("async_rst_missed", int'(missed), 0);
    model_reset();
    push_exp();
    quiet(2);
    rst_next = 1'b1;
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ring", int'(ring), int'(e.ring));
        check("snoozed", int'(snoozed), int'(e.snoozed));
        check("active_slot", int'(active_slot), e.slot);
        check("snoozes_left", int'(snoozes_left), e.left);
        check("missed", int'(missed), int'(e.missed));
      end
    end
  end

  initial begin
    int k, r;
    int pre_h[4] = '{7, 23, 0, 12};
    int pre_m[4] = '{30, 59, 0, 1};
    model_reset();
    rst_next = 1'b0;
    quiet(3);
    rst_next = 1'b1;

    // Single slot trigger, then dismiss.
    cfg(1, 1, 7, 30);
    set_time(7, 29, 59);
    tk(1);
    quiet(3);
    drive(0, 0, 1);
    quiet(2);

    // Two slots at the same time: lowest index wins; no re-trigger after dismiss.
    cfg(0, 1, 6, 0);
    cfg(2, 1, 6, 0);
    set_time(5, 59, 59);
    tk(1);
    quiet(4);
    drive(0, 0, 1);
    tk(20);

    // Snooze cycles, snooze exhaustion, then timeout.
    set_time(7, 29, 59);
    tk(1);
    for (int i = 0; i < MAX_SNOOZE; i++) begin
      tk(1);
      drive(0, 1, 0);
      tk(SNZ_TICKS);
    end
    drive(0, 1, 0);
    tk(RING_TIMEOUT_S);
    quiet(2);

    // Snooze with dismiss; snooze on the timeout tick.
    set_time(7, 29, 59);
    tk(1);
    drive(0, 1, 1);
    quiet(1);
    set_time(7, 29, 59);
    tk(1);
    tk(RING_TIMEOUT_S - 1);
    drive(1, 1, 0);
    tk(3);
    drive(0, 0, 1);

    // Cancel by disabling the active slot; other slot writes have no effect.
    cfg(3, 1, 8, 0);
    set_time(7, 59, 59);
    tk(1);
    drive(0, 1, 0);
    cfg(3, 1, 8, 5);
    cfg(2, 0, 6, 0);
    tk(3);
    cfg(3, 0, 8, 0);
    quiet(2);

    // Reset in the middle of ringing.
    set_time(7, 29, 59);
    tk(1);
    quiet(2);
    reset_pulse();
    set_time(7, 29, 59);
    tk(3);

    // Random traffic including midnight wrap.
    for (int i = 0; i < SLOTS; i++) cfg(i, 1, pre_h[i], pre_m[i]);
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        k = $urandom_range(0, 3);
        set_time(pre_h[k], pre_m[k], 0);
        if (pre_m[k] == 0) begin
          set_time((pre_h[k] + 23) % 24, 59, $urandom_range(57, 59));
        end else begin
          set_time(pre_h[k], pre_m[k] - 1, $urandom_range(57, 59));
        end
      end
      if (n == 2000) reset_pulse();
      if ($urandom_range(0, 29) == 0) begin
        k = $urandom_range(0, 3);
        if ($urandom_range(0, 9) == 0)
          drive($urandom_range(0, 3) != 0, 0, 0, 1, $urandom_range(0, 3),
                $urandom_range(0, 3) != 0, 30, 0);
        else
          drive($urandom_range(0, 3) != 0, 0, 0, 1, $urandom_range(0, 3),
                $urandom_range(0, 3) != 0, pre_h[k], pre_m[k]);
      end else begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 59) == 0);
      end
    end
    quiet(3);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
